// File: rtl/floppy_sdram_bridge_if.sv
// Bus bundle between the floppy SDRAM window, the bridge and the shared SDRAM controller.
// slave = bridge view, master = floppy/controller environment view.
interface floppy_sdram_bridge_if;
    logic [22:0] f_addr;
    logic [7:0]  f_data_i;
    logic [7:0]  f_data_o;
    logic        f_rd;
    logic        f_wr;
    logic        f_busy;
    logic        slot;
    logic [21:0] m_addr;
    logic [15:0] m_data_o;
    logic [1:0]  m_be;
    logic        m_rd;
    logic        m_wr;
    logic        m_ack;
    logic [15:0] m_data_i;
    logic        snoop_wr;
    logic [21:0] snoop_addr;
    logic [1:0]  dbg_state;

    modport slave (
        input  f_addr, f_data_i, f_rd, f_wr, slot, m_ack, m_data_i, snoop_wr, snoop_addr,
        output f_data_o, f_busy, m_addr, m_data_o, m_be, m_rd, m_wr, dbg_state
    );

    modport master (
        output f_addr, f_data_i, f_rd, f_wr, slot, m_ack, m_data_i, snoop_wr, snoop_addr,
        input  f_data_o, f_busy, m_addr, m_data_o, m_be, m_rd, m_wr, dbg_state
    );
endinterface

// File: rtl/floppy_sdram_bridge.sv
// Byte-to-word bridge from the floppy SDRAM window to the 16-bit SDRAM controller,
// with a one-word write-through read buffer kept coherent by host write snooping.
//
// state     | meaning
// IDLE      | accepting strobes; buffered read hits answered here
// WAIT_SLOT | request latched, waiting for the controller grant window
// REQ       | m_rd/m_wr held until m_ack
module floppy_sdram_bridge (
    input  logic                 clk,
    input  logic                 reset_n,
    floppy_sdram_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        REQ       = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [22:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  f_data_q, f_data_d;
    logic [1:0]  be_q, be_d;
    logic        is_wr_q, is_wr_d;
    logic        m_rd_q, m_rd_d;
    logic        m_wr_q, m_wr_d;
    logic        valid_q, valid_d;
    logic [15:0] buf_q, buf_d;
    logic [21:0] tag_q, tag_d;
    logic        hit;
    logic        req_tag_match;

    assign hit           = valid_q && (tag_q == bus.f_addr[22:1]);
    assign req_tag_match = valid_q && (tag_q == addr_q[22:1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            f_data_q <= '0;
            be_q     <= '0;
            is_wr_q  <= 1'b0;
            m_rd_q   <= 1'b0;
            m_wr_q   <= 1'b0;
            valid_q  <= 1'b0;
            buf_q    <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            f_data_q <= f_data_d;
            be_q     <= be_d;
            is_wr_q  <= is_wr_d;
            m_rd_q   <= m_rd_d;
            m_wr_q   <= m_wr_d;
            valid_q  <= valid_d;
            buf_q    <= buf_d;
            tag_q    <= tag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        f_data_d = f_data_q;
        be_d     = be_q;
        is_wr_d  = is_wr_q;
        m_rd_d   = m_rd_q;
        m_wr_d   = m_wr_q;
        valid_d  = valid_q;
        buf_d    = buf_q;
        tag_d    = tag_q;

        // Snoop invalidation goes first so a same-cycle read fill below can override it.
        if (bus.snoop_wr && (bus.snoop_addr == tag_q)) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.f_wr) begin
                    addr_d  = bus.f_addr;
                    wdata_d = bus.f_data_i;
                    be_d    = bus.f_addr[0] ? 2'b10 : 2'b01;
                    is_wr_d = 1'b1;
                    state_d = WAIT_SLOT;
                end else if (bus.f_rd) begin
                    if (hit) begin
                        f_data_d = bus.f_addr[0] ? buf_q[15:8] : buf_q[7:0];
                    end else begin
                        addr_d  = bus.f_addr;
                        be_d    = bus.f_addr[0] ? 2'b10 : 2'b01;
                        is_wr_d = 1'b0;
                        state_d = WAIT_SLOT;
                    end
                end
            end
            WAIT_SLOT: begin
                if (bus.slot) begin
                    m_rd_d  = !is_wr_q;
                    m_wr_d  = is_wr_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.m_ack) begin
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    state_d = IDLE;
                    if (is_wr_q) begin
                        if (req_tag_match) begin
                            if (addr_q[0]) buf_d[15:8] = wdata_q;
                            else           buf_d[7:0]  = wdata_q;
                        end
                    end else begin
                        f_data_d = addr_q[0] ? bus.m_data_i[15:8] : bus.m_data_i[7:0];
                        buf_d    = bus.m_data_i;
                        tag_d    = addr_q[22:1];
                        valid_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.f_busy    = (state_q != IDLE) | bus.f_wr | (bus.f_rd & ~hit);
    assign bus.f_data_o  = f_data_q;
    assign bus.m_addr    = addr_q[22:1];
    assign bus.m_data_o  = {wdata_q, wdata_q};
    assign bus.m_be      = be_q;
    assign bus.m_rd      = m_rd_q;
    assign bus.m_wr      = m_wr_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_floppy_sdram_bridge.sv
// Bench for floppy_sdram_bridge: directed scenarios plus random traffic checked against
// a word-memory model and a spec-level buffer model (valid/tag only, data taken from memory).
module tb_floppy_sdram_bridge;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    floppy_sdram_bridge_if bus ();

    floppy_sdram_bridge dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: SDRAM contents, plus whether the bridge should hold a coherent copy of word mtag.
    logic [15:0] mem [logic [21:0]];
    bit          mvalid;
    logic [21:0] mtag;
    logic [7:0]  mfdo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sel(input logic [15:0] wd, input logic hi);
        return hi ? wd[15:8] : wd[7:0];
    endfunction

    task automatic touch(input logic [21:0] w);
        if (!mem.exists(w)) mem[w] = 16'($urandom);
    endtask

    task automatic host_snoop(input logic [21:0] w);
        mem[w]         = 16'($urandom);
        bus.snoop_wr   = 1'b1;
        bus.snoop_addr = w;
        step();
        bus.snoop_wr   = 1'b0;
        #1;
        if (mvalid && mtag == w) mvalid = 1'b0;
        chk("snoop_idle_busy", 32'(bus.f_busy), 32'(0));
    endtask

    task automatic idle_ack();
        bus.m_ack    = 1'b1;
        bus.m_data_i = 16'($urandom);
        step();
        bus.m_ack    = 1'b0;
        #1;
        chk("stray_ack_state", 32'(bus.dbg_state), 32'(0));
        chk("stray_ack_data", 32'(bus.f_data_o), 32'(mfdo));
        chk("stray_ack_noreq", 32'(bus.m_rd | bus.m_wr), 32'(0));
    endtask

    // One floppy access: sw extra cycles without slot, aw extra cycles without ack.
    task automatic xact(input bit wr, input bit rd_too, input logic [22:0] a, input logic [7:0] d,
                        input int sw, input int aw, input bit inject, input bit snoop_ack);
        logic [21:0] w;
        bit          hit;
        int          busy_n;
        w = a[22:1];
        touch(w);
        hit = !wr && mvalid && (mtag == w);
        bus.f_addr   = a;
        bus.f_data_i = d;
        bus.f_wr     = wr;
        bus.f_rd     = !wr || rd_too;
        #1;
        chk("busy_at_strobe", 32'(bus.f_busy), 32'(!hit));
        busy_n = int'(bus.f_busy);
        step();
        bus.f_wr = 1'b0;
        bus.f_rd = 1'b0;
        #1;
        if (hit) begin
            mfdo = sel(mem[w], a[0]);
            chk("hit_data", 32'(bus.f_data_o), 32'(mfdo));
            chk("hit_busy", 32'(bus.f_busy), 32'(0));
            chk("hit_noreq", 32'(bus.m_rd | bus.m_wr), 32'(0));
            chk("hit_state", 32'(bus.dbg_state), 32'(0));
        end else begin
            for (int i = 0; i <= sw; i++) begin
                chk("wait_state", 32'(bus.dbg_state), 32'(1));
                chk("wait_noreq", 32'(bus.m_rd | bus.m_wr), 32'(0));
                chk("wait_busy", 32'(bus.f_busy), 32'(1));
                busy_n += int'(bus.f_busy);
                bus.slot = (i == sw);
                if (inject && i == sw) begin
                    bus.f_rd   = 1'b1;
                    bus.f_addr = a ^ 23'h000400;
                end
                step();
                bus.slot = 1'b0;
                bus.f_rd = 1'b0;
                #1;
            end
            for (int i = 0; i <= aw; i++) begin
                chk("req_state", 32'(bus.dbg_state), 32'(2));
                chk("req_m_rd", 32'(bus.m_rd), 32'(!wr));
                chk("req_m_wr", 32'(bus.m_wr), 32'(wr));
                chk("req_m_addr", 32'(bus.m_addr), 32'(w));
                chk("req_m_be", 32'(bus.m_be), a[0] ? 32'd2 : 32'd1);
                if (wr) chk("req_m_data", 32'(bus.m_data_o), 32'({d, d}));
                chk("req_busy", 32'(bus.f_busy), 32'(1));
                busy_n += int'(bus.f_busy);
                if (i == aw) begin
                    if (snoop_ack && !wr) begin
                        mem[w]         = 16'($urandom);
                        bus.snoop_wr   = 1'b1;
                        bus.snoop_addr = w;
                    end
                    bus.m_ack    = 1'b1;
                    bus.m_data_i = wr ? 16'($urandom) : mem[w];
                end
                step();
                bus.m_ack    = 1'b0;
                bus.snoop_wr = 1'b0;
                #1;
            end
            if (wr) begin
                mem[w] = a[0] ? {d, mem[w][7:0]} : {mem[w][15:8], d};
            end else begin
                mvalid = 1'b1;
                mtag   = w;
                mfdo   = sel(mem[w], a[0]);
            end
            chk("done_state", 32'(bus.dbg_state), 32'(0));
            chk("done_noreq", 32'(bus.m_rd | bus.m_wr), 32'(0));
            chk("done_busy", 32'(bus.f_busy), 32'(0));
            chk("done_data", 32'(bus.f_data_o), 32'(mfdo));
            chk("busy_cycles", 32'(busy_n), 32'(3 + sw + aw));
        end
    endtask

    initial begin
        logic [22:0] ra;
        int          r;
        total  = 0;
        bad    = 0;
        mvalid = 1'b0;
        mtag   = '0;
        mfdo   = '0;
        reset_n        = 1'b0;
        bus.f_addr     = '0;
        bus.f_data_i   = '0;
        bus.f_rd       = 1'b0;
        bus.f_wr       = 1'b0;
        bus.slot       = 1'b0;
        bus.m_ack      = 1'b0;
        bus.m_data_i   = '0;
        bus.snoop_wr   = 1'b0;
        bus.snoop_addr = '0;
        #1;
        chk("rst_state", 32'(bus.dbg_state), 32'(0));
        chk("rst_req", 32'({bus.m_rd, bus.m_wr}), 32'(0));
        chk("rst_m_addr", 32'(bus.m_addr), 32'(0));
        chk("rst_m_be", 32'(bus.m_be), 32'(0));
        chk("rst_m_data", 32'(bus.m_data_o), 32'(0));
        chk("rst_f_data", 32'(bus.f_data_o), 32'(0));
        chk("rst_busy", 32'(bus.f_busy), 32'(0));
        step();
        step();
        reset_n = 1'b1;
        step();

        // Miss then hit on word 0x12345.
        mem[22'h12345] = 16'hBEEF;
        xact(1'b0, 1'b0, 23'h2468B, 8'h00, 0, 0, 1'b0, 1'b0);
        chk("miss_hi_byte", 32'(bus.f_data_o), 32'hBE);
        xact(1'b0, 1'b0, 23'h2468A, 8'h00, 0, 0, 1'b0, 1'b0);
        chk("hit_lo_byte", 32'(bus.f_data_o), 32'hEF);

        // Write merge into a buffered word.
        mem[22'h00010] = 16'hBEEF;
        xact(1'b0, 1'b0, 23'h00020, 8'h00, 0, 0, 1'b0, 1'b0);
        xact(1'b1, 1'b0, 23'h00021, 8'h5A, 0, 0, 1'b0, 1'b0);
        xact(1'b0, 1'b0, 23'h00021, 8'h00, 0, 0, 1'b0, 1'b0);
        chk("merge_read", 32'(bus.f_data_o), 32'h5A);

        // Slot stall and ack stall.
        xact(1'b1, 1'b0, 23'h00444, 8'hC3, 10, 0, 1'b0, 1'b0);
        xact(1'b0, 1'b0, 23'h00445, 8'h00, 2, 5, 1'b0, 1'b0);

        // Snoop: other word keeps the hit, matching word forces a miss.
        xact(1'b0, 1'b0, 23'h00200, 8'h00, 0, 0, 1'b0, 1'b0);
        host_snoop(22'h00101);
        xact(1'b0, 1'b0, 23'h00200, 8'h00, 0, 0, 1'b0, 1'b0);
        host_snoop(22'h00100);
        xact(1'b0, 1'b0, 23'h00200, 8'h00, 0, 0, 1'b0, 1'b0);
        // Snoop coinciding with fill: fill wins, next read hits.
        xact(1'b0, 1'b0, 23'h00600, 8'h00, 0, 1, 1'b0, 1'b1);
        xact(1'b0, 1'b0, 23'h00601, 8'h00, 0, 0, 1'b0, 1'b0);

        // Collision and strobe during busy.
        xact(1'b1, 1'b1, 23'h00601, 8'h77, 1, 0, 1'b1, 1'b0);
        bus.slot = 1'b1;
        step();
        step();
        bus.slot = 1'b0;
        #1;
        chk("no_second_req", 32'(bus.m_rd | bus.m_wr), 32'(0));
        chk("no_second_busy", 32'(bus.dbg_state), 32'(0));
        idle_ack();

        // Reset while a read request is outstanding.
        xact(1'b0, 1'b0, 23'h00300, 8'h00, 0, 0, 1'b0, 1'b0);
        touch(22'h00181);
        bus.f_addr = 23'h00302;
        bus.f_rd   = 1'b1;
        step();
        bus.f_rd = 1'b0;
        bus.slot = 1'b1;
        step();
        bus.slot = 1'b0;
        #1;
        chk("pre_rst_m_rd", 32'(bus.m_rd), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_m_rd", 32'(bus.m_rd), 32'(0));
        chk("mid_rst_state", 32'(bus.dbg_state), 32'(0));
        chk("mid_rst_f_data", 32'(bus.f_data_o), 32'(0));
        step();
        reset_n = 1'b1;
        mvalid  = 1'b0;
        mfdo    = '0;
        idle_ack();
        xact(1'b0, 1'b0, 23'h00300, 8'h00, 0, 0, 1'b0, 1'b0);

        // Random traffic over 8 words.
        for (int n = 0; n < 250; n++) begin
            r  = int'($urandom_range(0, 9));
            ra = 23'h000100 + 23'($urandom_range(0, 15));
            if (r < 5) begin
                xact(1'b0, 1'b0, ra, 8'h00, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            end else if (r < 8) begin
                xact(1'b1, ($urandom_range(0, 3) == 0), ra, 8'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
            end else if (r == 8) begin
                host_snoop(ra[22:1]);
            end else begin
                idle_ack();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
